// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: seeds a 12-bit LFSR, steps it for a programmed count or one full
// period, and reports the step count. Optional macro PAUSE_EN adds a pause input.
module lfsr_run_ctrl #(
  parameter int LFSR_W = 12,
  parameter int CNT_W  = 13
) (
  input  logic              CCLK,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  step_count,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_en,
  input  logic [LFSR_W-1:0] lfsr_out,
  input  logic              max_tick,
`ifdef PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result,
  output logic              wrapped,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   step_reg;
  logic [CNT_W-1:0]   cnt;
  logic               hit_wrap;
  logic               hit_limit;
  logic               hit_sat;
  logic               stop;
  logic               run_hold;
  logic               unused_lfsr_out;

  // The LFSR state is only observed by the user; the FSM relies on max_tick.
  assign unused_lfsr_out = ^lfsr_out;

`ifdef PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  // max_tick at cnt==0 is the freshly loaded seed, not a completed period.
  assign hit_wrap  = (cnt != '0) && max_tick;
  assign hit_limit = (step_reg != '0) && (cnt == step_reg);
  assign hit_sat   = (cnt == {CNT_W{1'b1}});
  assign stop      = hit_wrap || hit_limit || hit_sat;

  // Enable is combinational so a stop seen this cycle suppresses this edge's step.
  assign lfsr_en = (state == RUN) && !stop && !run_hold && !reset;

  always_ff @(posedge CCLK) begin
    if (reset) begin
      state     <= IDLE;
      step_reg  <= '0;
      cnt       <= '0;
      lfsr_load <= 1'b0;
      lfsr_seed <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      wrapped   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      lfsr_load <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // All-zero is the LFSR lockup state, so it is never loaded.
            lfsr_seed <= (seed == '0) ? LFSR_W'(1) : seed;
            step_reg  <= step_count;
            cnt       <= '0;
            result    <= '0;
            wrapped   <= 1'b0;
            overflow  <= 1'b0;
            lfsr_load <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          state <= RUN;
        end
        RUN: begin
          if (stop) begin
            result   <= cnt;
            wrapped  <= hit_wrap;
            overflow <= !hit_wrap && !hit_limit;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (lfsr_en) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
